// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO-to-stream adapter.
package fifo_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam int STATS_W = 32;

    // Pointer width for a circular store of 'depth' entries; never narrower than 1 bit.
    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/adapter_buf.sv
// Circular BUF_DEPTH x DATA_WIDTH store with explicit pointer wrap (depth need not be a power of 2).
module adapter_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    input  logic                             push,
    input  logic [DATA_WIDTH-1:0]            push_data,
    input  logic                             pop,
    output logic [DATA_WIDTH-1:0]            head,
    output logic [$clog2(BUF_DEPTH+1)-1:0]   occupancy
);

    localparam int PW = ptr_w(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wrap_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            if (push && !pop) begin
                occupancy <= occupancy + 1'b1;
            end else if (pop && !push) begin
                occupancy <= occupancy - 1'b1;
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_adapter.sv
// Turns a 1-cycle-latency FIFO read port into a valid/ready stream.
// Optional FIFO_ADAPTER_STATS_EN adds transfer and stall counters.
module fifo_stream_adapter
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             fifo_empty,
    output logic                             fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]            fifo_rd_data,
    input  logic                             flush,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [DATA_WIDTH-1:0]            m_data,
    output logic [$clog2(BUF_DEPTH+1)-1:0]   occupancy
`ifdef FIFO_ADAPTER_STATS_EN
    ,
    output logic [STATS_W-1:0]               xfer_cnt,
    output logic [STATS_W-1:0]               stall_cnt
`endif
);

    localparam int OW = $clog2(BUF_DEPTH + 1);

    state_t        state;
    state_t        state_next;
    logic          inflight;
    logic          run;
    logic          clear;
    logic          push;
    logic          pop;
    logic [OW:0]   level;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (flush)  state_next = FLUSH;
            FLUSH:   if (!flush) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    assign run   = (state == RUN);
    assign clear = flush | !run;

    // Issue counts the word already on the wire so the buffer can never overflow.
    // Reset gating keeps upstream words from being popped into a buffer that is being cleared.
    assign level      = {1'b0, occupancy} + {{OW{1'b0}}, inflight};
    assign fifo_rd_en = run & !rst & !fifo_empty & !flush & (level < (OW+1)'(BUF_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    assign push    = inflight & run;
    assign m_valid = (occupancy != '0) & run & !flush;
    assign pop     = m_valid & m_ready;

    adapter_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .push      (push),
        .push_data (fifo_rd_data),
        .pop       (pop),
        .head      (m_data),
        .occupancy (occupancy)
    );

`ifdef FIFO_ADAPTER_STATS_EN
    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (m_valid && m_ready) begin
                xfer_cnt <= xfer_cnt + 1'b1;
            end
            if (m_valid && !m_ready) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Directed bench: behavioural upstream FIFO (word k holds k+1) plus in-order stream scoreboard.
module tb_fifo_stream_adapter;

    localparam int DW = 8;
    localparam int BD = 3;
    localparam int OW = $clog2(BD + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [OW-1:0] occupancy;
`ifdef FIFO_ADAPTER_STATS_EN
    logic [31:0]   xfer_cnt;
    logic [31:0]   stall_cnt;
`endif

    logic [DW-1:0] mem [64];
    int            wr_lim = 0;
    int            rd_idx = 0;
    int            exp_idx = 0;
    logic          gap = 1'b0;
    int            n_chk = 0;
    int            n_bad = 0;

    fifo_stream_adapter #(.DATA_WIDTH(DW), .BUF_DEPTH(BD)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .flush        (flush),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .occupancy    (occupancy)
`ifdef FIFO_ADAPTER_STATS_EN
        ,
        .xfer_cnt     (xfer_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign fifo_empty = (rd_idx >= wr_lim) | gap;

    // Upstream FIFO: data_out valid the cycle after an accepted pop.
    always @(posedge clk) begin
        if (rst) begin
            rd_idx       <= 0;
            fifo_rd_data <= '0;
        end else if (fifo_rd_en) begin
            fifo_rd_data <= mem[rd_idx[5:0]];
            rd_idx       <= rd_idx + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Words popped before or during a flush are gone; delivery resumes at the next pop.
    always @(negedge clk) begin
        if (rst) begin
            exp_idx = 0;
        end else begin
            chk("rd_on_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
            if (flush) begin
                chk("valid_in_flush", 32'(m_valid), 32'd0);
                exp_idx = rd_idx;
            end else if (m_valid && m_ready) begin
                chk("stream_data", 32'(m_data), 32'(mem[exp_idx[5:0]]));
                exp_idx = exp_idx + 1;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag, input int target);
        int k;
        k = 0;
        while (exp_idx < target && k < 200) begin
            cyc(1);
            k++;
        end
        chk(tag, 32'(exp_idx), 32'(target));
    endtask

    task automatic restart(input int words, input logic ready);
        rst     = 1'b1;
        m_ready = ready;
        cyc(2);
        wr_lim = words;
        rst    = 1'b0;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(i + 1);
        rst     = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b0;
        wr_lim  = 20;

        // reset with a non-empty FIFO
        cyc(1);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        cyc(1);
        chk("rst_rd_en2", 32'(fifo_rd_en), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);

        // full-rate streaming
        restart(8, 1'b1);
        chk("t2_rd_first", 32'(fifo_rd_en), 32'd1);
        chk("t2_valid_c1", 32'(m_valid), 32'd0);
        cyc(1);
        chk("t2_valid_c2", 32'(m_valid), 32'd0);
        cyc(1);
        chk("t2_valid_c3", 32'(m_valid), 32'd1);
        chk("t2_data_c3", 32'(m_data), 32'h01);
        for (int i = 0; i < 7; i++) begin
            cyc(1);
            chk("t2_nobubble", 32'(m_valid), 32'd1);
        end
        wait_drain("t2_count", 8);

        // backpressure fills exactly BUF_DEPTH entries
        restart(20, 1'b0);
        cyc(8);
        chk("t3_pops", 32'(rd_idx), 32'd3);
        chk("t3_occ", 32'(occupancy), 32'd3);
        chk("t3_rd_en", 32'(fifo_rd_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("t3_hold", 32'(m_data), 32'h01);
        end
        m_ready = 1'b1;
        wait_drain("t3_count", 20);

        // flush with occupancy 2 and one word in flight
        restart(20, 1'b0);
        cyc(3);
        chk("t4_occ", 32'(occupancy), 32'd2);
        chk("t4_rd_en", 32'(fifo_rd_en), 32'd0);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        #1;
        chk("t4_valid", 32'(m_valid), 32'd0);
        chk("t4_occ0", 32'(occupancy), 32'd0);
        m_ready = 1'b1;
        begin
            int k;
            k = 0;
            while (!m_valid && k < 20) begin
                cyc(1);
                k++;
            end
        end
        chk("t4_first", 32'(m_data), 32'h04);
        wait_drain("t4_count", 20);

        // FIFO toggling empty every cycle
        restart(10, 1'b1);
        for (int i = 0; i < 30; i++) begin
            gap = ~gap;
            cyc(1);
        end
        gap = 1'b0;
        wait_drain("t5_count", 10);

`ifdef FIFO_ADAPTER_STATS_EN
        restart(5, 1'b0);
        begin
            int k;
            k = 0;
            while (!m_valid && k < 20) begin
                cyc(1);
                k++;
            end
        end
        cyc(4);
        m_ready = 1'b1;
        wait_drain("t6_count", 5);
        cyc(2);
        chk("t6_xfer", xfer_cnt, 32'd5);
        chk("t6_stall", stall_cnt, 32'd4);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        cyc(2);
        chk("t6_xfer_fl", xfer_cnt, 32'd5);
        chk("t6_stall_fl", stall_cnt, 32'd4);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
